// File: rtl/decode_pipe_stage.sv
// Decode stage between fetch and execute: splits instruction fields, registers them
// with PC+1, and handles valid/ready flow, load-use bubbles and branch flushes.
module decode_pipe_stage #(
  parameter int          REG_WIDTH    = 16,
  parameter int          ADDR_W       = 4,
  parameter int          IMM_W        = 11,
  parameter logic [4:0]  LOAD_OPCODE  = 5'h10,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_1_if_valid,
  output logic                 o_1_if_ready,
  input  logic [15:0]          i_16_instr,
  input  logic [REG_WIDTH-1:0] i_R_pcplus,
  input  logic                 i_1_flush,
  input  logic                 i_1_ex_ready,
  input  logic [REG_WIDTH-1:0] i_R_alu_out,
  input  logic [REG_WIDTH-1:0] i_R_mem_data,
  input  logic                 i_1_mem2reg_sel,
  input  logic [ADDR_W-1:0]    i_A_reg_wr_addr,
  input  logic                 i_1_reg_wr_en,
  output logic                 or_1_id_valid,
  output logic [4:0]           or_5_opcode,
  output logic [ADDR_W-1:0]    or_A_rd_addr,
  output logic [ADDR_W-1:0]    or_A_rs1_addr,
  output logic [ADDR_W-1:0]    or_A_rs2_addr,
  output logic [IMM_W-1:0]     or_I_imm,
  output logic [REG_WIDTH-1:0] or_R_pcplus,
  output logic [REG_WIDTH-1:0] or_R_wr_data,
  output logic [ADDR_W-1:0]    or_A_reg_wr_addr,
  output logic                 or_1_reg_wr_en,
  output logic                 o_1_stall
);

  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HAZ   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 id_valid_q, id_valid_d;
  logic [4:0]           opcode_q, opcode_d;
  logic [ADDR_W-1:0]    rd_q, rd_d;
  logic [ADDR_W-1:0]    rs1_q, rs1_d;
  logic [ADDR_W-1:0]    rs2_q, rs2_d;
  logic [IMM_W-1:0]     imm_q, imm_d;
  logic [REG_WIDTH-1:0] pcplus_q, pcplus_d;

  logic [REG_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
  logic                 wr_en_q, wr_en_d;

  logic [ADDR_W-1:0]    rd_f, rs1_f, rs2_f;
  logic                 advance;
  logic                 hazard;
  logic                 load_beat;
  logic                 if_ready_c;
  logic                 stall_c;

  // 3-bit register fields are zero-extended to the register-file address width.
  always_comb begin
    rd_f       = '0;
    rs1_f      = '0;
    rs2_f      = '0;
    rd_f[2:0]  = i_16_instr[10:8];
    rs1_f[2:0] = i_16_instr[5:3];
    rs2_f[2:0] = i_16_instr[2:0];
  end

  assign advance = !id_valid_q || i_1_ex_ready;
  assign hazard  = id_valid_q && (opcode_q == LOAD_OPCODE) && i_1_if_valid &&
                   ((rd_q == rs1_f) || (rd_q == rs2_f));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    id_valid_d = id_valid_q;
    opcode_d   = opcode_q;
    rd_d       = rd_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    imm_d      = imm_q;
    pcplus_d   = pcplus_q;
    if_ready_c = 1'b0;
    stall_c    = 1'b0;
    load_beat  = 1'b0;

    case (state_q)
      ST_RUN: begin
        if_ready_c = advance && !hazard;
        if (advance) begin
          if (hazard) begin
            id_valid_d = 1'b0;
            stall_c    = 1'b1;
            state_d    = ST_HAZ;
          end else if (i_1_if_valid) begin
            load_beat = 1'b1;
          end else begin
            id_valid_d = 1'b0;
          end
        end
      end
      ST_HAZ: begin
        // The bubble now sitting in ID cannot create a new hazard, so just take the held beat.
        if_ready_c = advance;
        if (advance) begin
          if (i_1_if_valid) begin
            load_beat = 1'b1;
          end else begin
            id_valid_d = 1'b0;
          end
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if_ready_c = 1'b1;
        id_valid_d = 1'b0;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d    = ST_RUN;
        id_valid_d = 1'b0;
      end
    endcase

    if (load_beat && !i_1_flush) begin
      id_valid_d = 1'b1;
      opcode_d   = i_16_instr[15:11];
      rd_d       = rd_f;
      rs1_d      = rs1_f;
      rs2_d      = rs2_f;
      imm_d      = i_16_instr[IMM_W-1:0];
      pcplus_d   = i_R_pcplus;
    end

    // A taken branch overrides everything: the same-cycle beat is swallowed too.
    if (i_1_flush) begin
      id_valid_d = 1'b0;
      stall_c    = 1'b0;
      cnt_d      = CNT_W'(FLUSH_CYCLES);
      state_d    = ST_FLUSH;
    end
  end

  always_comb begin
    wr_data_d = i_1_mem2reg_sel ? i_R_mem_data : i_R_alu_out;
    wr_addr_d = i_A_reg_wr_addr;
    wr_en_d   = i_1_reg_wr_en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      cnt_q      <= '0;
      id_valid_q <= 1'b0;
      opcode_q   <= '0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      imm_q      <= '0;
      pcplus_q   <= '0;
      wr_data_q  <= '0;
      wr_addr_q  <= '0;
      wr_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      id_valid_q <= id_valid_d;
      opcode_q   <= opcode_d;
      rd_q       <= rd_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      imm_q      <= imm_d;
      pcplus_q   <= pcplus_d;
      wr_data_q  <= wr_data_d;
      wr_addr_q  <= wr_addr_d;
      wr_en_q    <= wr_en_d;
    end
  end

  assign o_1_if_ready     = if_ready_c && !rst;
  assign o_1_stall        = stall_c && !rst;
  assign or_1_id_valid    = id_valid_q;
  assign or_5_opcode      = opcode_q;
  assign or_A_rd_addr     = rd_q;
  assign or_A_rs1_addr    = rs1_q;
  assign or_A_rs2_addr    = rs2_q;
  assign or_I_imm         = imm_q;
  assign or_R_pcplus      = pcplus_q;
  assign or_R_wr_data     = wr_data_q;
  assign or_A_reg_wr_addr = wr_addr_q;
  assign or_1_reg_wr_en   = wr_en_q;

endmodule
